sec32_encoder: RTL and testbench
================================

SEC32_ENCODER -- requirements
Module: sec32_encoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the accepted-word counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, upstream word valid.
REQ-005 SHALL have port in_ready, output, 1, encoder can accept a word.
REQ-006 SHALL have port in_data, input, 32, data word; bit k is d[k].
REQ-007 SHALL have port chk_en, input, 1, check-bit enable, sampled with each accepted word.
REQ-008 SHALL have port inj_en, input, 1, test error injection, sampled with each accepted word.
REQ-009 SHALL have port inj_bit, input, 5, index of the data bit flipped when inj_en=1.
REQ-010 SHALL have port out_valid, output, 1, codeword valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the codeword.
REQ-012 SHALL have port out_data, output, 32, data portion of the codeword.
REQ-013 SHALL have port out_chk, output, 8, check bits c[7:0].
REQ-014 SHALL have port word_cnt, output, CNT_W, count of words accepted since reset.

Function
REQ-015 SHALL accept a word on every cycle with in_valid=1 and in_ready=1.
REQ-016 SHALL deliver a codeword on every cycle with out_valid=1 and out_ready=1.
REQ-017 SHALL define check bits as XOR reductions: c0=d16..d23^d0^d4^d8^d12; c1=d24..d31^d1^d5^d9^d13; c2=d16..d19^d24..d27^d2^d6^d10^d14; c3=d20..d23^d28..d31^d3^d7^d11^d15.
REQ-018 SHALL define c4=d0..d7^d16^d20^d24^d28; c5=d8..d15^d17^d21^d25^d29; c6=d0..d3^d8..d11^d18^d22^d26^d30; c7=d4..d7^d12..d15^d19^d23^d27^d31.
REQ-019 SHALL force out_chk=8'h00 when the word's sampled chk_en=0.
REQ-020 SHALL use a 2-stage pipeline: stage 1 registers data, 8 row-group parities, 8 column parities and the sampled controls; stage 2 registers the combined check bits and the data.
REQ-021 SHALL present a word on out_valid exactly 2 cycles after acceptance when out_ready stays 1.
REQ-022 SHALL apply injection in stage 2 after check computation: out_data = data XOR (1<<inj_bit), out_chk unchanged.
REQ-023 SHALL set in_ready = !s1_valid || (s1 advances this cycle); stage 1 advances when !s2_valid || out_ready.
REQ-024 SHALL hold out_data and out_chk stable while out_valid=1 and out_ready=0.
REQ-025 SHALL sustain one word per cycle with out_ready held at 1, with no bubbles.
REQ-026 SHALL hold at most 2 words in flight; with out_ready=0 and both stages full, in_ready=0.
REQ-027 SHALL increment word_cnt on each accepted word and wrap from all-ones to 0.
REQ-028 SHALL drop no word and duplicate no word, including when an input accept and an output release occur in the same cycle.

Reset
REQ-029 SHALL, with rst_n=0, immediately clear s1_valid, s2_valid, out_valid, word_cnt, out_data and out_chk to 0.
REQ-030 SHALL discard any in-flight word on reset mid-operation and emit no partial codeword afterwards.
REQ-031 SHALL drive in_ready=1 from the first clock edge after rst_n deasserts.

Structure
REQ-032 SHALL place the check-bit group masks (8 row masks, 8 column masks, 32 bits each) and the width constants in package sec32_pkg.
REQ-033 SHALL implement REQ-017/REQ-018 as a sub-module sec32_chk_gen, combinational, used by stage 2; the same masks SHALL serve the matching decoder.

Verification
REQ-034 SHALL cover: word 32'h00000000, chk_en=1 -> out_chk=8'h00, out_valid 2 cycles later.
REQ-035 SHALL cover: words 32'h00000001, 32'h00010000, 32'hFFFFFFFF back-to-back -> out_chk 8'h51, 8'h15, 8'h00 on consecutive cycles.
REQ-036 SHALL cover: word 32'h00000008, inj_en=1, inj_bit=3 -> out_data=32'h00000000, out_chk=8'h58.
REQ-037 SHALL cover: out_ready=0 while 3 words are offered -> in_ready=0 after 2 accepts; on release, all 3 words exit in order with stable outputs.
REQ-038 SHALL cover: rst_n pulsed low with 2 words in flight -> out_valid=0 and word_cnt=0 at once; the next word yields the correct codeword.
REQ-039 SHALL cover: CNT_W=4 with 17 accepted words -> word_cnt=1.

Source files
------------

// File: rtl/sec32_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sec32_pkg : widths, parity group masks and stage-1 record for the SEC32 code
// Rev 1.0
// ---------------------------------------------------------------------------
package sec32_pkg;

  localparam int DATA_W = 32;
  localparam int CHK_W  = 8;
  localparam int IDX_W  = 5;

  // Check bit i = parity(data & ROW_MASK[i]) ^ parity(data & COL_MASK[i]).
  // The decoder reuses these masks to rebuild the syndrome.
  localparam logic [CHK_W-1:0][DATA_W-1:0] ROW_MASK = {
    32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FF00, 32'h0000_00FF,
    32'hF0F0_0000, 32'h0F0F_0000, 32'hFF00_0000, 32'h00FF_0000
  };

  localparam logic [CHK_W-1:0][DATA_W-1:0] COL_MASK = {
    32'h8888_0000, 32'h4444_0000, 32'h2222_0000, 32'h1111_0000,
    32'h0000_8888, 32'h0000_4444, 32'h0000_2222, 32'h0000_1111
  };

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CHK_W-1:0]  row;
    logic [CHK_W-1:0]  col;
    logic              chk_en;
    logic              inj_en;
    logic [IDX_W-1:0]  inj_bit;
  } s1_t;

endpackage
`default_nettype wire

// File: rtl/sec32_chk_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sec32_chk_gen : group parities from a data word, and their combination into
//                 the final check byte. Purely combinational. Rev 1.0
// ---------------------------------------------------------------------------
module sec32_chk_gen
  import sec32_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [CHK_W-1:0]  row_q,
  input  logic [CHK_W-1:0]  col_q,
  input  logic              chk_en,
  output logic [CHK_W-1:0]  row_par,
  output logic [CHK_W-1:0]  col_par,
  output logic [CHK_W-1:0]  chk
);

  for (genvar i = 0; i < CHK_W; i++) begin : g_grp
    assign row_par[i] = ^(data & ROW_MASK[i]);
    assign col_par[i] = ^(data & COL_MASK[i]);
  end

  assign chk = chk_en ? (row_q ^ col_q) : '0;

endmodule
`default_nettype wire

// File: rtl/sec32_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sec32_encoder : 2-stage valid/ready SEC check-bit encoder with error inject
// Rev 1.0
// ---------------------------------------------------------------------------
module sec32_encoder
  import sec32_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              chk_en,
  input  logic              inj_en,
  input  logic [IDX_W-1:0]  inj_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CHK_W-1:0]  out_chk,
  output logic [CNT_W-1:0]  word_cnt
);

  s1_t              s1_q;
  logic             s1_valid;
  logic             s2_valid;
  logic             s1_adv;
  logic             accept;
  logic [CHK_W-1:0] row_par;
  logic [CHK_W-1:0] col_par;
  logic [CHK_W-1:0] chk_d;
  logic [DATA_W-1:0] inj_mask;

  assign s1_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s1_adv;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  sec32_chk_gen u_chk_gen (
    .data    (in_data),
    .row_q   (s1_q.row),
    .col_q   (s1_q.col),
    .chk_en  (s1_q.chk_en),
    .row_par (row_par),
    .col_par (col_par),
    .chk     (chk_d)
  );

  // Injection flips data only after the check bits were formed from clean data.
  assign inj_mask = s1_q.inj_en ? ({{(DATA_W-1){1'b0}}, 1'b1} << s1_q.inj_bit) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q <= '{data: in_data, row: row_par, col: col_par,
                  chk_en: chk_en, inj_en: inj_en, inj_bit: inj_bit};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_chk  <= '0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s1_q.data ^ inj_mask;
        out_chk  <= chk_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (accept) begin
      word_cnt <= word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sec32_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sec32_encoder : table + scoreboard bench for sec32_encoder. Rev 1.0
// ---------------------------------------------------------------------------
module tb_sec32_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        chk_en, inj_en;
  logic [4:0]  inj_bit;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_chk;
  logic [15:0] word_cnt;

  logic        in_valid4, in_ready4, out_valid4;
  logic        out_ready4 = 1'b1;
  logic [31:0] out_data4;
  logic [7:0]  out_chk4;
  logic [3:0]  word_cnt4;

  always #5 clk = ~clk;

  sec32_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .chk_en(chk_en), .inj_en(inj_en), .inj_bit(inj_bit),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chk(out_chk), .word_cnt(word_cnt)
  );

  sec32_encoder #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data), .chk_en(chk_en), .inj_en(inj_en), .inj_bit(inj_bit),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .out_chk(out_chk4), .word_cnt(word_cnt4)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  chk;
    int          acc;
    bit          lat;
  } sb_t;

  typedef struct {
    logic [31:0] d;
    bit          ce;
    bit          ie;
    logic [4:0]  ib;
    logic [31:0] ed;
    logic [7:0]  ec;
  } vec_t;

  sb_t         sb[$];
  vec_t        vt[10];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  bit          lat_mode = 0;
  logic [31:0] exp_data;
  logic [7:0]  exp_chk;
  bit          prev_stall = 0;
  logic [31:0] prev_data;
  logic [7:0]  prev_chk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_chk(input logic [31:0] d);
    logic [7:0] c;
    c[0] = (^d[23:16]) ^ d[0] ^ d[4] ^ d[8]  ^ d[12];
    c[1] = (^d[31:24]) ^ d[1] ^ d[5] ^ d[9]  ^ d[13];
    c[2] = (^d[19:16]) ^ (^d[27:24]) ^ d[2] ^ d[6] ^ d[10] ^ d[14];
    c[3] = (^d[23:20]) ^ (^d[31:28]) ^ d[3] ^ d[7] ^ d[11] ^ d[15];
    c[4] = (^d[7:0])   ^ d[16] ^ d[20] ^ d[24] ^ d[28];
    c[5] = (^d[15:8])  ^ d[17] ^ d[21] ^ d[25] ^ d[29];
    c[6] = (^d[3:0])   ^ (^d[11:8])  ^ d[18] ^ d[22] ^ d[26] ^ d[30];
    c[7] = (^d[7:4])   ^ (^d[15:12]) ^ d[19] ^ d[23] ^ d[27] ^ d[31];
    return c;
  endfunction

  task automatic drive(input logic [31:0] d, input bit ce, input bit ie, input logic [4:0] ib,
                       input logic [31:0] ed, input logic [7:0] ec);
    in_data = d; chk_en = ce; inj_en = ie; inj_bit = ib;
    exp_data = ed; exp_chk = ec;
  endtask

  task automatic drive_model(input logic [31:0] d, input bit ce, input bit ie, input logic [4:0] ib);
    logic [31:0] one = 32'd1;
    drive(d, ce, ie, ib, ie ? (d ^ (one << ib)) : d, ce ? model_chk(d) : 8'h00);
  endtask

  // Hold a word on the input until it is taken; entered and left at posedge+1.
  task automatic send();
    int n = 0;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_queue_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_out_valid", out_valid, 1);
        check("stall_out_data", out_data, prev_data);
        check("stall_out_chk", out_chk, prev_chk);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output actual=%h/%h required=none", out_data, out_chk);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_chk", out_chk, e.chk);
          if (e.lat) check("latency", cyc - e.acc, 2);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back('{data: exp_data, chk: exp_chk, acc: cyc, lat: lat_mode});
        acc_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_chk   = out_chk;
    end else begin
      prev_stall = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{32'h0000_0000, 1, 0, 5'd0,  32'h0000_0000, 8'h00};
    vt[1] = '{32'h0000_0001, 1, 0, 5'd0,  32'h0000_0001, 8'h51};
    vt[2] = '{32'h0001_0000, 1, 0, 5'd0,  32'h0001_0000, 8'h15};
    vt[3] = '{32'hFFFF_FFFF, 1, 0, 5'd0,  32'hFFFF_FFFF, 8'h00};
    vt[4] = '{32'h0000_0008, 1, 1, 5'd3,  32'h0000_0000, 8'h58};
    vt[5] = '{32'h0000_0001, 0, 0, 5'd0,  32'h0000_0001, 8'h00};
    vt[6] = '{32'h8000_0000, 1, 0, 5'd0,  32'h8000_0000, 8'h8A};
    vt[7] = '{32'h0000_0003, 1, 0, 5'd0,  32'h0000_0003, 8'h03};
    vt[8] = '{32'h0010_0000, 1, 0, 5'd0,  32'h0010_0000, 8'h19};
    vt[9] = '{32'h0000_0100, 1, 1, 5'd0,  32'h0000_0101, 8'h61};

    rst_n = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1;
    drive(32'h0, 1, 0, 5'd0, 32'h0, 8'h00);
    #3;
    check("reset_out_valid", out_valid, 0);
    check("reset_word_cnt", word_cnt, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_chk", out_chk, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", in_ready, 1);

    // Back-to-back table vectors with a free-flowing output.
    lat_mode = 1;
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].d, vt[i].ce, vt[i].ie, vt[i].ib, vt[i].ed, vt[i].ec);
      send();
    end
    for (int i = 0; i < 30; i++) begin
      drive_model($urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  5'($urandom_range(0, 31)));
      send();
    end
    drain();
    lat_mode = 0;

    // Random valid and backpressure.
    for (int i = 0; i < 80; i++) begin
      drive_model($urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  5'($urandom_range(0, 31)));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 2) != 0;
      @(posedge clk); #1;
    end
    drain();

    // Three words offered against a stalled output.
    out_ready = 1'b0;
    drive_model(32'hA5A5_0001, 1, 0, 5'd0);
    send();
    drive_model(32'h0F0F_1234, 1, 1, 5'd17);
    send();
    drive_model(32'hDEAD_BEEF, 1, 0, 5'd0);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    check("word_cnt_total", word_cnt, acc_cnt);

    // Reset with two words in flight.
    out_ready = 1'b0;
    drive_model(32'h1111_2222, 1, 0, 5'd0);
    send();
    drive_model(32'h3333_4444, 1, 0, 5'd0);
    send();
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_word_cnt", word_cnt, 0);
    check("midreset_out_chk", out_chk, 0);
    sb.delete();
    acc_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_midreset", in_ready, 1);
    lat_mode = 1;
    drive(32'h0000_0001, 1, 0, 5'd0, 32'h0000_0001, 8'h51);
    send();
    drain();
    lat_mode = 0;
    check("word_cnt_after_midreset", word_cnt, 1);

    // Narrow counter wraps: 17 accepts on a 4-bit counter.
    in_valid4 = 1'b1;
    repeat (17) @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    check("cnt4_wrap", word_cnt4, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
